// File: rtl/pac_game_sequencer_if.sv
// Maze-wall lookup handshake between the game sequencer and the wall map.
// The sequencer holds blk_req with a stable (blk_x, blk_y) until a one-cycle
// blk_ack returns blk_wall.
interface pac_game_sequencer_if;
  logic       blk_req;
  logic [9:0] blk_x;
  logic [8:0] blk_y;
  logic       blk_ack;
  logic       blk_wall;

  modport master (output blk_req, blk_x, blk_y, input blk_ack, blk_wall);
  modport slave  (input blk_req, blk_x, blk_y, output blk_ack, blk_wall);
endinterface

// File: rtl/pac_game_sequencer.sv
// Game-level controller: owns IDLE/PLAY/WIN/LOSE, chases Pac-Man with the
// ghost through a wall-lookup handshake, and keeps score, dots and lives.
module pac_game_sequencer #(
  parameter int GHOST_X0     = 200,
  parameter int GHOST_Y0     = 146,
  parameter int STEP         = 2,
  parameter int HIT_DIST     = 16,
  parameter int LIVES        = 3,
  parameter int DOTS_TOTAL   = 200,
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int FREEZE_TICKS = 32
) (
  input  logic                        clk,
  input  logic                        clrn,
  input  logic                        start,
  input  logic                        pause,
  input  logic                        move_tick,
  input  logic [9:0]                  pac_x,
  input  logic [9:0]                  pac_y,
  input  logic                        dot_eaten,
  pac_game_sequencer_if.master        blk,
  output logic [1:0]                  state,
  output logic [9:0]                  ghost_x,
  output logic [8:0]                  ghost_y,
  output logic [1:0]                  lives,
  output logic [15:0]                 score,
  output logic                        pac_reset
);

  localparam int FW = $clog2(FREEZE_TICKS + 1);

  localparam logic signed [10:0] STEP_S      = 11'(STEP);
  localparam logic signed [10:0] XMAX_S      = 11'(X_MAX);
  localparam logic signed [10:0] YMAX_S      = 11'(Y_MAX);
  localparam logic        [10:0] HIT_U       = 11'(HIT_DIST);
  localparam logic        [9:0]  GX0         = 10'(GHOST_X0);
  localparam logic        [8:0]  GY0         = 9'(GHOST_Y0);
  localparam logic        [1:0]  LIVES_INIT  = 2'(LIVES);
  localparam logic        [7:0]  DOTS_LAST   = 8'(DOTS_TOTAL - 1);
  localparam logic        [FW-1:0] FREEZE_INIT = FW'(FREEZE_TICKS);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    WIN  = 2'b10,
    LOSE = 2'b11
  } game_t;

  typedef enum logic [1:0] {
    G_WAIT,
    G_REQ1,
    G_REQ2
  } ghost_t;

  game_t         gs;
  ghost_t        gst;
  logic          req;
  logic [9:0]    bx;
  logic [8:0]    by;
  logic [9:0]    sec_x;
  logic [8:0]    sec_y;
  logic          sec_ok;
  logic          discard;
  logic [7:0]    dots;
  logic [FW-1:0] freeze;

  logic signed [10:0] gx_s, gy_s, dx, dy, cand_x, cand_y;
  logic        [10:0] adx, ady;
  logic               x_ok, y_ok, x_first, hit_raw;
  logic        [9:0]  prim_x, sec_x_c;
  logic        [8:0]  prim_y, sec_y_c;
  logic               prim_ok, sec_ok_c;
  logic               play, dot_win, hit_eff, start_fire, drop, accept;

  assign blk.blk_req = req;
  assign blk.blk_x   = bx;
  assign blk.blk_y   = by;
  assign state       = gs;

  // Chase geometry, collision test and event qualification for this cycle.
  always_comb begin
    gx_s    = signed'({1'b0, ghost_x});
    gy_s    = signed'({2'b00, ghost_y});
    dx      = signed'({1'b0, pac_x}) - gx_s;
    dy      = signed'({1'b0, pac_y}) - gy_s;
    adx     = dx[10] ? 11'(-dx) : 11'(dx);
    ady     = dy[10] ? 11'(-dy) : 11'(dy);
    cand_x  = dx[10] ? (gx_s - STEP_S) : (gx_s + STEP_S);
    cand_y  = dy[10] ? (gy_s - STEP_S) : (gy_s + STEP_S);
    x_ok    = !cand_x[10] && (cand_x <= XMAX_S);
    y_ok    = !cand_y[10] && (cand_y <= YMAX_S);
    x_first = (adx >= ady);
    prim_x  = x_first ? cand_x[9:0] : ghost_x;
    prim_y  = x_first ? ghost_y     : cand_y[8:0];
    prim_ok = x_first ? x_ok        : y_ok;
    sec_x_c = x_first ? ghost_x     : cand_x[9:0];
    sec_y_c = x_first ? cand_y[8:0] : ghost_y;
    sec_ok_c = x_first ? y_ok       : x_ok;
    hit_raw = (adx < HIT_U) && (ady < HIT_U);

    play       = (gs == PLAY);
    dot_win    = play && dot_eaten && (dots == DOTS_LAST);
    hit_eff    = play && !pause && (freeze == '0) && hit_raw && !dot_win;
    start_fire = !play && start;
    drop       = discard || hit_eff || !play;
    accept     = play && move_tick && !pause && (freeze == '0) && !hit_eff &&
                 (gst == G_WAIT);
  end

  // Game state, counters and the ghost lookup handshake.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      gs        <= IDLE;
      gst       <= G_WAIT;
      ghost_x   <= GX0;
      ghost_y   <= GY0;
      lives     <= LIVES_INIT;
      score     <= '0;
      dots      <= '0;
      freeze    <= '0;
      req       <= 1'b0;
      bx        <= '0;
      by        <= '0;
      sec_x     <= '0;
      sec_y     <= '0;
      sec_ok    <= 1'b0;
      discard   <= 1'b0;
      pac_reset <= 1'b0;
    end else begin
      pac_reset <= 1'b0;

      // A hit or restart taints the in-flight lookup; the completion branches
      // below clear this again when the lookup retires.
      if ((hit_eff || start_fire) && (gst != G_WAIT))
        discard <= 1'b1;

      unique case (gst)
        G_WAIT: begin
          if (accept) begin
            sec_x  <= sec_x_c;
            sec_y  <= sec_y_c;
            sec_ok <= sec_ok_c;
            if (prim_ok) begin
              req <= 1'b1;
              bx  <= prim_x;
              by  <= prim_y;
              gst <= G_REQ1;
            end else if (sec_ok_c) begin
              req <= 1'b1;
              bx  <= sec_x_c;
              by  <= sec_y_c;
              gst <= G_REQ2;
            end
          end
        end
        G_REQ1: begin
          if (blk.blk_ack) begin
            req <= 1'b0;
            if (drop) begin
              gst     <= G_WAIT;
              discard <= 1'b0;
            end else if (!blk.blk_wall) begin
              ghost_x <= bx;
              ghost_y <= by;
              gst     <= G_WAIT;
            end else if (sec_ok) begin
              bx  <= sec_x;
              by  <= sec_y;
              gst <= G_REQ2;
            end else begin
              gst <= G_WAIT;
            end
          end
        end
        G_REQ2: begin
          // req low here is the single idle cycle after a primary wall ack
          if (!req) begin
            if (drop) begin
              gst     <= G_WAIT;
              discard <= 1'b0;
            end else begin
              req <= 1'b1;
            end
          end else if (blk.blk_ack) begin
            req     <= 1'b0;
            gst     <= G_WAIT;
            discard <= 1'b0;
            if (!drop && !blk.blk_wall) begin
              ghost_x <= bx;
              ghost_y <= by;
            end
          end
        end
        default: gst <= G_WAIT;
      endcase

      // Game-level updates come last so a spawn reset overrides a move commit.
      if (start_fire) begin
        gs        <= PLAY;
        lives     <= LIVES_INIT;
        score     <= '0;
        dots      <= '0;
        freeze    <= '0;
        ghost_x   <= GX0;
        ghost_y   <= GY0;
        pac_reset <= 1'b1;
      end else if (play) begin
        if (dot_eaten) begin
          score <= (score > 16'd65525) ? 16'hFFFF : score + 16'd10;
          dots  <= dots + 8'd1;
          if (dot_win)
            gs <= WIN;
        end
        if (hit_eff) begin
          lives     <= lives - 2'd1;
          ghost_x   <= GX0;
          ghost_y   <= GY0;
          pac_reset <= 1'b1;
          freeze    <= FREEZE_INIT;
          if (lives == 2'd1)
            gs <= LOSE;
        end else if (move_tick && !pause && (freeze != '0)) begin
          freeze <= freeze - FW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pac_game_sequencer.sv
// Bench for pac_game_sequencer: directed scenarios plus randomized play,
// compared every cycle against a candidate-list reference model.
module tb_pac_game_sequencer;

  localparam int GX0    = 200;
  localparam int GY0    = 146;
  localparam int STEP   = 2;
  localparam int HIT    = 16;
  localparam int LIVES0 = 3;
  localparam int DOTS   = 3;
  localparam int XMAX   = 639;
  localparam int YMAX   = 479;
  localparam int FRZ    = 32;

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic        start = 1'b0, pause = 1'b0, move_tick = 1'b0, dot_eaten = 1'b0;
  logic [9:0]  pac_x = '0, pac_y = '0;
  logic [1:0]  state, lives;
  logic [9:0]  ghost_x;
  logic [8:0]  ghost_y;
  logic [15:0] score;
  logic        pac_reset;

  pac_game_sequencer_if bus ();

  pac_game_sequencer #(.DOTS_TOTAL(DOTS)) dut (
    .clk(clk), .clrn(clrn), .start(start), .pause(pause), .move_tick(move_tick),
    .pac_x(pac_x), .pac_y(pac_y), .dot_eaten(dot_eaten), .blk(bus),
    .state(state), .ghost_x(ghost_x), .ghost_y(ghost_y), .lives(lives),
    .score(score), .pac_reset(pac_reset)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int x; int y; } cand_t;

  // Reference model: pending lookups are a list of legal candidates in
  // preference order; a wall answer pops the head and the next one follows
  // after one idle cycle.
  int    m_state, m_gx, m_gy, m_lives, m_score, m_dots, m_freeze, m_bx, m_by;
  bit    m_req, m_gap, m_discard, m_pr;
  cand_t cq[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_gx = GX0; m_gy = GY0; m_lives = LIVES0; m_score = 0;
    m_dots = 0; m_freeze = 0; m_bx = 0; m_by = 0;
    m_req = 0; m_gap = 0; m_discard = 0; m_pr = 0;
    cq.delete();
  endtask

  function automatic void push_if_legal(input int x, input int y);
    cand_t c;
    if (x >= 0 && x <= XMAX && y >= 0 && y <= YMAX) begin
      c.x = x; c.y = y;
      cq.push_back(c);
    end
  endfunction

  task automatic model_update();
    int dx, dy, adx, ady, sx, sy;
    bit play, dwin, ehit, sfire, drop, acc;
    int n_state, n_gx, n_gy, n_lives, n_score, n_dots, n_freeze, n_bx, n_by;
    bit n_req, n_gap, n_discard, n_pr;
    if (!clrn) begin
      model_reset();
      return;
    end
    play  = (m_state == 1);
    dx    = int'(pac_x) - m_gx;
    dy    = int'(pac_y) - m_gy;
    adx   = (dx < 0) ? -dx : dx;
    ady   = (dy < 0) ? -dy : dy;
    dwin  = play && dot_eaten && (m_dots + 1 == DOTS);
    ehit  = play && !pause && (m_freeze == 0) && adx < HIT && ady < HIT && !dwin;
    sfire = !play && start;
    drop  = m_discard || ehit || !play;
    acc   = play && move_tick && !pause && (m_freeze == 0) && !ehit && !m_req && !m_gap;

    n_state = m_state; n_gx = m_gx; n_gy = m_gy; n_lives = m_lives;
    n_score = m_score; n_dots = m_dots; n_freeze = m_freeze;
    n_bx = m_bx; n_by = m_by; n_req = m_req; n_gap = m_gap; n_pr = 0;

    if (m_req && bus.blk_ack) begin
      n_req = 0;
      if (drop) cq.delete();
      else if (!bus.blk_wall) begin
        n_gx = m_bx; n_gy = m_by;
        cq.delete();
      end else begin
        void'(cq.pop_front());
        if (cq.size() > 0) n_gap = 1;
      end
    end else if (m_gap) begin
      n_gap = 0;
      if (drop) cq.delete();
      else begin
        n_req = 1; n_bx = cq[0].x; n_by = cq[0].y;
      end
    end else if (acc) begin
      sx = (dx >= 0) ? STEP : -STEP;
      sy = (dy >= 0) ? STEP : -STEP;
      cq.delete();
      if (adx >= ady) begin
        push_if_legal(m_gx + sx, m_gy);
        push_if_legal(m_gx, m_gy + sy);
      end else begin
        push_if_legal(m_gx, m_gy + sy);
        push_if_legal(m_gx + sx, m_gy);
      end
      if (cq.size() > 0) begin
        n_req = 1; n_bx = cq[0].x; n_by = cq[0].y;
      end
    end
    n_discard = (n_req || n_gap) && (m_discard || ehit || sfire);

    if (sfire) begin
      n_state = 1; n_lives = LIVES0; n_score = 0; n_dots = 0; n_freeze = 0;
      n_gx = GX0; n_gy = GY0; n_pr = 1;
    end else if (play) begin
      if (dot_eaten) begin
        n_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
        n_dots  = m_dots + 1;
        if (dwin) n_state = 2;
      end
      if (ehit) begin
        n_lives = m_lives - 1; n_gx = GX0; n_gy = GY0; n_pr = 1; n_freeze = FRZ;
        if (n_lives == 0) n_state = 3;
      end else if (move_tick && !pause && m_freeze > 0) begin
        n_freeze = m_freeze - 1;
      end
    end

    m_state = n_state; m_gx = n_gx; m_gy = n_gy; m_lives = n_lives;
    m_score = n_score; m_dots = n_dots; m_freeze = n_freeze;
    m_bx = n_bx; m_by = n_by; m_req = n_req; m_gap = n_gap;
    m_discard = n_discard; m_pr = n_pr;
  endtask

  task automatic compare_all();
    check("state", int'(state), m_state);
    check("ghost_x", int'(ghost_x), m_gx);
    check("ghost_y", int'(ghost_y), m_gy);
    check("lives", int'(lives), m_lives);
    check("score", int'(score), m_score);
    check("pac_reset", int'(pac_reset), int'(m_pr));
    check("blk_req", int'(bus.blk_req), int'(m_req));
    if (m_req) begin
      check("blk_x", int'(bus.blk_x), m_bx);
      check("blk_y", int'(bus.blk_y), m_by);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge,
  // then single-cycle pulses are withdrawn.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
    start = 0; move_tick = 0; dot_eaten = 0;
    bus.blk_ack = 0; bus.blk_wall = 0;
  endtask

  task automatic async_reset();
    #1 clrn = 0;
    #1;
    check("rst_async_req", int'(bus.blk_req), 0);
    check("rst_async_state", int'(state), 0);
    model_reset();
    step();
    clrn = 1;
  endtask

  task automatic restart();
    pac_x = 0; pac_y = 0; pause = 0;
    async_reset();
    start = 1;
    step();
  endtask

  int last_tick;
  int t;

  initial begin
    bus.blk_ack = 0;
    bus.blk_wall = 0;
    model_reset();
    #2 clrn = 0;
    @(negedge clk);
    @(negedge clk);
    compare_all();
    check("reset_state", int'(state), 0);
    check("reset_ghost_x", int'(ghost_x), 200);
    check("reset_ghost_y", int'(ghost_y), 146);
    check("reset_lives", int'(lives), 3);
    check("reset_score", int'(score), 0);
    check("reset_blk_req", int'(bus.blk_req), 0);
    check("reset_blk_xy", int'(bus.blk_x) + int'(bus.blk_y), 0);
    clrn = 1;

    // start: PLAY with a one-cycle pac_reset
    start = 1; step();
    check("start_state", int'(state), 1);
    check("start_pac_reset", int'(pac_reset), 1);
    step();
    check("start_pac_reset_low", int'(pac_reset), 0);

    // blocked primary, then secondary at (200,148)
    pac_x = 300; pac_y = 200;
    move_tick = 1; step();
    check("blk1_req", int'(bus.blk_req), 1);
    check("blk1_x", int'(bus.blk_x), 202);
    check("blk1_y", int'(bus.blk_y), 146);
    bus.blk_ack = 1; bus.blk_wall = 1; step();
    check("blk_gap", int'(bus.blk_req), 0);
    step();
    check("blk2_req", int'(bus.blk_req), 1);
    check("blk2_x", int'(bus.blk_x), 200);
    check("blk2_y", int'(bus.blk_y), 148);
    bus.blk_ack = 1; bus.blk_wall = 0; step();
    check("blk2_commit_y", int'(ghost_y), 148);
    check("blk2_commit_x", int'(ghost_x), 200);
    step();
    move_tick = 1; step();
    bus.blk_ack = 1; bus.blk_wall = 1; step();
    step();
    bus.blk_ack = 1; bus.blk_wall = 1; step();
    check("both_walls_x", int'(ghost_x), 200);
    check("both_walls_y", int'(ghost_y), 148);

    // chase along x
    restart();
    pac_x = 300; pac_y = 146;
    move_tick = 1; step();
    check("chase_blk_x", int'(bus.blk_x), 202);
    check("chase_blk_y", int'(bus.blk_y), 146);
    step();
    bus.blk_ack = 1; bus.blk_wall = 0; step();
    check("chase_ghost_x", int'(ghost_x), 202);
    check("chase_req_drop", int'(bus.blk_req), 0);

    // collision, freeze window, and third hit loses
    restart();
    pac_x = 210; pac_y = 150; step();
    check("hit1_lives", int'(lives), 2);
    check("hit1_ghost_x", int'(ghost_x), 200);
    check("hit1_pac_reset", int'(pac_reset), 1);
    step();
    check("hit1_pulse_end", int'(pac_reset), 0);
    for (int i = 0; i < 31; i++) begin
      move_tick = 1; step(); step();
    end
    check("frozen_31", int'(lives), 2);
    move_tick = 1; step();
    check("tick32_lives", int'(lives), 2);
    step();
    check("hit2_lives", int'(lives), 1);
    for (int i = 0; i < 32; i++) begin
      move_tick = 1; step(); step();
    end
    check("hit3_lose", int'(state), 3);
    check("hit3_lives", int'(lives), 0);
    dot_eaten = 1; step();
    check("lose_dot_ignored", int'(score), 0);

    // win takes priority over a simultaneous hit
    restart();
    dot_eaten = 1; step();
    step();
    dot_eaten = 1; step();
    check("two_dots", int'(score), 20);
    pac_x = 210; pac_y = 150; dot_eaten = 1; step();
    check("win_state", int'(state), 2);
    check("win_score", int'(score), 30);
    check("win_lives", int'(lives), 3);

    // bounds: x candidate 640 is illegal, y candidate requested instead
    restart();
    pac_x = 700; pac_y = 146;
    for (int i = 0; i < 219; i++) begin
      move_tick = 1; step();
      bus.blk_ack = 1; step();
      step();
    end
    check("bound_ghost_x", int'(ghost_x), 638);
    move_tick = 1; step();
    check("bound_req", int'(bus.blk_req), 1);
    check("bound_blk_x", int'(bus.blk_x), 638);
    check("bound_blk_y", int'(bus.blk_y), 148);
    bus.blk_ack = 1; step();
    check("bound_commit_y", int'(ghost_y), 148);

    // reset mid-lookup, then pause
    restart();
    pac_x = 300; pac_y = 146;
    move_tick = 1; step();
    check("mid_req", int'(bus.blk_req), 1);
    async_reset();
    start = 1; step();
    pause = 1;
    for (int i = 0; i < 4; i++) begin
      move_tick = 1; step();
      check("pause_no_req", int'(bus.blk_req), 0);
      step();
    end
    dot_eaten = 1; step();
    check("pause_dot", int'(score), 10);
    pause = 0;

    // randomized play
    last_tick = 0;
    for (int c = 0; c < 8000; c++) begin
      if ($urandom_range(0, 599) == 0) async_reset();
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      if (m_state != 1 && $urandom_range(0, 7) == 0) start = 1;
      if ($urandom_range(0, 63) == 0) start = 1;
      move_tick = (last_tick == 0) && ($urandom_range(0, 3) == 0);
      last_tick = int'(move_tick);
      if ($urandom_range(0, 39) == 0) dot_eaten = 1;
      if (m_req) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.blk_ack = 1; bus.blk_wall = 1'($urandom_range(0, 1));
        end
      end else if ($urandom_range(0, 15) == 0) begin
        bus.blk_ack = 1; bus.blk_wall = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          t = m_gx + $urandom_range(0, 48) - 24;
          pac_x = 10'((t < 0) ? 0 : t);
          t = m_gy + $urandom_range(0, 48) - 24;
          pac_y = 10'((t < 0) ? 0 : t);
        end else begin
          pac_x = 10'($urandom_range(0, 1023));
          pac_y = 10'($urandom_range(0, 600));
        end
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
